alu16_seq: RTL
==============

# alu16_seq

Sequencer that runs 16-bit operations (ADD HL,rr / INC rr / DEC rr / ADD SP,e8) on the shared 8-bit ALU. It makes two byte passes, low then high, and carries the low-byte carry/borrow into the high pass. It sits between the CPU control unit and `alu8`, and drives `alu8`'s ports itself while busy. It returns the 16-bit result and the merged F-register value with a one-cycle done pulse.

## Interface
- No parameters.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request; sampled only in IDLE.
- `op` in 2: 00 ADD16, 01 INC16, 10 DEC16, 11 ADDSPE.
- `opnd_a` in 16: HL / rr / SP.
- `opnd_b` in 16: rr for ADD16; [7:0] = e8 for ADDSPE; ignored for INC16/DEC16.
- `flags_in` in 8: current F (Z=7, N=6, H=5, C=4).
- `alu_a`, `alu_b` out 8: to `alu8` regA/regB.
- `alu_op` out 4: to `alu8` opcode.
- `alu_cin` out 1: to `alu8` carryIn.
- `alu_res` in 8: from `alu8` res.
- `alu_flags` in 8: from `alu8` flagsOut.
- `busy` out 1: high in LOW/HIGH.
- `done` out 1: one-cycle pulse, result valid.
- `result` out 16: registered; held until the next done.
- `flags_out` out 8: registered merged F; held until the next done.

## Operation
- States: IDLE → LOW → HIGH → DONE → IDLE.
  - IDLE→LOW on `start`; `op`/operands/`flags_in` latched.
  - LOW→HIGH, HIGH→DONE, DONE→IDLE unconditional.
- Effective B operand:
  - ADD16: `opnd_b`.
  - INC16/DEC16: 0x0001.
  - ADDSPE: {8{e8[7]}, e8}.
- LOW pass:
  - `alu_a`=A[7:0], `alu_b`=B[7:0], `alu_cin`=0.
  - `alu_op`=0000 (ADD), or 0010 (SUB) for DEC16.
  - Capture `alu_res`→res_lo and `alu_flags`[5:4]→h_lo, c_lo.
- HIGH pass:
  - `alu_a`=A[15:8], `alu_b`=B[15:8], `alu_cin`=c_lo.
  - `alu_op`=0001 (ADC), or 0011 (SBC) for DEC16.
  - Capture {`alu_res`, res_lo}→result and flags.
- Flag merge (all others from latched `flags_in`):
  - ADD16: Z kept, N=0, H=high-pass H, C=high-pass C.
  - INC16/DEC16: F unchanged.
  - ADDSPE: Z=0, N=0, H=h_lo, C=c_lo.
  - Bits [3:0] always 0.
- IDLE/DONE ALU drive: `alu_a`=`alu_b`=0, `alu_op`=0000, `alu_cin`=0.
- `start` in LOW/HIGH/DONE: ignored, not queued.
- 16-bit wrap is modular: 0xFFFF+1=0x0000, 0x0000−1=0xFFFF.

## Timing
- Reset: state IDLE; `busy`=0, `done`=0, `result`=0x0000, `flags_out`=0x00, ALU drive as in IDLE.
- Reset in any state takes effect at the next edge. An in-flight op is abandoned with no `done`.
- `start` sampled at edge 0:
  - LOW during cycle 1, HIGH during cycle 2.
  - `done`=1 during cycle 3, with `result`/`flags_out` already valid.
  - Next `start` accepted at the edge ending cycle 4 (IDLE); throughput one op per 4 cycles.
- ALU outputs are combinational from state and latched operands. `alu8` is combinational, so each pass completes in one cycle.

## Configuration
- `ALU16_SEQ_FASTINC_EN` defined:
  - INC16/DEC16 go LOW→DONE when c_lo=0.
  - High byte is copied unchanged; `done` arrives in cycle 2.
  - All other ops and the c_lo=1 case are unchanged.
- Undefined: every op takes the full 3-cycle latency.

## Structure
- Shared package `veriboy_alu_pkg`:
  - `alu8` opcode constants (OP_ADD…OP_SWAP).
  - Flag bit indices (FLAG_Z=7, FLAG_N=6, FLAG_H=5, FLAG_C=4).
  - Seq op encodings and the state enum.
- No sub-module. `alu8` is instantiated by the parent and shared.
- The bench instantiates `alu8` alongside `alu16_seq`.

## Test plan
- ADD16 A=0x0FFF, B=0x0001, `flags_in`=0x80 → done in cycle 3, `result`=0x1000, `flags_out`=0xA0.
- ADD16 A=0xFFFF, B=0x0001, `flags_in`=0x00 → `result`=0x0000, `flags_out`=0x30.
- INC16 A=0x00FF, `flags_in`=0x50 → 0x0100, 0x50. DEC16 A=0x0000, `flags_in`=0xC0 → 0xFFFF, 0xC0.
- ADDSPE A=0xFFF8, e8=0x08, `flags_in`=0x80 → `result`=0x0000, `flags_out`=0x30.
- `start` pulsed in LOW and HIGH: ignored, single `done`. `rst` in HIGH: next cycle IDLE, `busy`=0, `result`=0, no `done`.
- With `ALU16_SEQ_FASTINC_EN`: INC16 0x1234 → 0x1235, done in cycle 2. INC16 0x12FF → 0x1300, done in cycle 3.

Source files
------------

// File: rtl/veriboy_alu_pkg.sv
// Shared definitions for the 8-bit ALU and the 16-bit operation sequencer:
// alu8 opcodes, F-register bit positions, sequencer op encodings and states.
package veriboy_alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADC  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SBC  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_CP   = 4'd7;
  localparam logic [3:0] OP_INC  = 4'd8;
  localparam logic [3:0] OP_DEC  = 4'd9;
  localparam logic [3:0] OP_RLC  = 4'd10;
  localparam logic [3:0] OP_RRC  = 4'd11;
  localparam logic [3:0] OP_RL   = 4'd12;
  localparam logic [3:0] OP_RR   = 4'd13;
  localparam logic [3:0] OP_SLA  = 4'd14;
  localparam logic [3:0] OP_SWAP = 4'd15;

  localparam int unsigned FLAG_Z = 7;
  localparam int unsigned FLAG_N = 6;
  localparam int unsigned FLAG_H = 5;
  localparam int unsigned FLAG_C = 4;

  typedef enum logic [1:0] {
    SEQ_ADD16  = 2'b00,
    SEQ_INC16  = 2'b01,
    SEQ_DEC16  = 2'b10,
    SEQ_ADDSPE = 2'b11
  } seq_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOW  = 2'b01,
    ST_HIGH = 2'b10,
    ST_DONE = 2'b11
  } seq_state_t;

  // Second operand seen by the two byte passes.
  function automatic logic [15:0] eff_b(seq_op_t op, logic [15:0] b);
    logic [15:0] r;
    case (op)
      SEQ_ADD16:  r = b;
      SEQ_ADDSPE: r = {{8{b[7]}}, b[7:0]};
      default:    r = 16'h0001;
    endcase
    return r;
  endfunction

  // Final F value; the low nibble of F is architecturally always zero.
  function automatic logic [7:0] merge_flags(seq_op_t op, logic [7:0] f,
                                             logic h_hi, logic c_hi,
                                             logic h_lo, logic c_lo);
    logic [7:0] m;
    m = {f[7:4], 4'h0};
    case (op)
      SEQ_ADD16: begin
        m[FLAG_N] = 1'b0;
        m[FLAG_H] = h_hi;
        m[FLAG_C] = c_hi;
      end
      SEQ_ADDSPE: begin
        m[FLAG_Z] = 1'b0;
        m[FLAG_N] = 1'b0;
        m[FLAG_H] = h_lo;
        m[FLAG_C] = c_lo;
      end
      default: ;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu8.sv
// Combinational 8-bit ALU shared by the CPU; flagsOut is {Z,N,H,C,0000}.
module alu8
  import veriboy_alu_pkg::*;
(
  input  logic [7:0] regA,
  input  logic [7:0] regB,
  input  logic [3:0] opcode,
  input  logic       carryIn,
  output logic [7:0] res,
  output logic [7:0] flagsOut
);

  logic [8:0] sum9;
  logic [4:0] nib5;
  logic       cin;
  logic       z, n, h, c;

  always_comb begin
    sum9 = '0;
    nib5 = '0;
    cin  = 1'b0;
    res  = '0;
    n    = 1'b0;
    h    = 1'b0;
    c    = 1'b0;
    case (opcode)
      OP_ADD, OP_ADC: begin
        cin  = (opcode == OP_ADC) && carryIn;
        sum9 = {1'b0, regA} + {1'b0, regB} + {8'h00, cin};
        nib5 = {1'b0, regA[3:0]} + {1'b0, regB[3:0]} + {4'h0, cin};
        res  = sum9[7:0];
        h    = nib5[4];
        c    = sum9[8];
      end
      OP_SUB, OP_SBC, OP_CP: begin
        // 9-bit subtraction: bit 8 set means a borrow out of the byte.
        cin  = (opcode == OP_SBC) && carryIn;
        sum9 = {1'b0, regA} - {1'b0, regB} - {8'h00, cin};
        nib5 = {1'b0, regA[3:0]} - {1'b0, regB[3:0]} - {4'h0, cin};
        res  = (opcode == OP_CP) ? regA : sum9[7:0];
        n    = 1'b1;
        h    = nib5[4];
        c    = sum9[8];
      end
      OP_AND:  begin res = regA & regB; h = 1'b1; end
      OP_XOR:  res = regA ^ regB;
      OP_OR:   res = regA | regB;
      OP_INC:  begin res = regA + 8'd1; h = (regA[3:0] == 4'hF); c = carryIn; end
      OP_DEC:  begin res = regA - 8'd1; n = 1'b1; h = (regA[3:0] == 4'h0); c = carryIn; end
      OP_RLC:  begin res = {regA[6:0], regA[7]}; c = regA[7]; end
      OP_RRC:  begin res = {regA[0], regA[7:1]}; c = regA[0]; end
      OP_RL:   begin res = {regA[6:0], carryIn}; c = regA[7]; end
      OP_RR:   begin res = {carryIn, regA[7:1]}; c = regA[0]; end
      OP_SLA:  begin res = {regA[6:0], 1'b0}; c = regA[7]; end
      OP_SWAP: res = {regA[3:0], regA[7:4]};
      default: ;
    endcase
  end

  assign z        = (opcode == OP_CP) ? (sum9[7:0] == 8'h00) : (res == 8'h00);
  assign flagsOut = {z, n, h, c, 4'h0};

endmodule

// File: rtl/alu16_seq.sv
// Runs 16-bit ADD/INC/DEC/ADD SP,e8 as two passes through the shared alu8.
// Optional feature: ALU16_SEQ_FASTINC_EN (INC16/DEC16 skip the high pass when no carry).
module alu16_seq
  import veriboy_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] opnd_a,
  input  logic [15:0] opnd_b,
  input  logic [7:0]  flags_in,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_op,
  output logic        alu_cin,
  input  logic [7:0]  alu_res,
  input  logic [7:0]  alu_flags,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [7:0]  flags_out
);

  seq_state_t  state_q, state_d;
  seq_op_t     op_q, op_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [7:0]  fin_q, fin_d;
  logic [7:0]  res_lo_q, res_lo_d;
  logic        h_lo_q, h_lo_d;
  logic        c_lo_q, c_lo_d;
  logic [15:0] result_q, result_d;
  logic [7:0]  flags_q, flags_d;
  logic        fast_take;
  logic        unused_bits;

`ifdef ALU16_SEQ_FASTINC_EN
  assign fast_take = ((op_q == SEQ_INC16) || (op_q == SEQ_DEC16)) && !alu_flags[FLAG_C];
`else
  assign fast_take = 1'b0;
`endif

  assign unused_bits = ^{alu_flags[7:6], alu_flags[3:0], fin_q[3:0]};

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOW;
      ST_LOW:  state_d = fast_take ? ST_DONE : ST_HIGH;
      ST_HIGH: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_op  = OP_ADD;
    alu_cin = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_LOW: begin
        busy   = 1'b1;
        alu_a  = a_q[7:0];
        alu_b  = b_q[7:0];
        alu_op = (op_q == SEQ_DEC16) ? OP_SUB : OP_ADD;
      end
      ST_HIGH: begin
        busy    = 1'b1;
        alu_a   = a_q[15:8];
        alu_b   = b_q[15:8];
        alu_op  = (op_q == SEQ_DEC16) ? OP_SBC : OP_ADC;
        alu_cin = c_lo_q;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    fin_d    = fin_q;
    res_lo_d = res_lo_q;
    h_lo_d   = h_lo_q;
    c_lo_d   = c_lo_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      ST_IDLE: if (start) begin
        op_d  = seq_op_t'(op);
        a_d   = opnd_a;
        b_d   = eff_b(seq_op_t'(op), opnd_b);
        fin_d = flags_in;
      end
      ST_LOW: begin
        res_lo_d = alu_res;
        h_lo_d   = alu_flags[FLAG_H];
        c_lo_d   = alu_flags[FLAG_C];
        // Skipped high pass: high byte passes through, F is unchanged for INC/DEC.
        if (fast_take) begin
          result_d = {a_q[15:8], alu_res};
          flags_d  = merge_flags(op_q, fin_q, 1'b0, 1'b0, 1'b0, 1'b0);
        end
      end
      ST_HIGH: begin
        result_d = {alu_res, res_lo_q};
        flags_d  = merge_flags(op_q, fin_q, alu_flags[FLAG_H], alu_flags[FLAG_C],
                               h_lo_q, c_lo_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= SEQ_ADD16;
      a_q      <= '0;
      b_q      <= '0;
      fin_q    <= '0;
      res_lo_q <= '0;
      h_lo_q   <= 1'b0;
      c_lo_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      fin_q    <= fin_d;
      res_lo_q <= res_lo_d;
      h_lo_q   <= h_lo_d;
      c_lo_q   <= c_lo_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign result    = result_q;
  assign flags_out = flags_q;

endmodule
